// File: rtl/reset_sequencer_staged.sv
// Staged multi-channel reset sequencer: hold all channels, release them in index order, then allow per-channel software re-reset.
// All outputs are registered; the first release is BaseCycle edges after the last rst edge.
module reset_sequencer_staged #(
   parameter int NumChannels = 4,
   parameter int BaseCycle   = 8,
   parameter int StageCycle  = 4,
   parameter int UseAck      = 0,
   parameter int AckTimeout  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic [NumChannels-1:0] rstOut,
   input  logic [NumChannels-1:0] ackIn,
   input  logic [NumChannels-1:0] swRstReq,
   output logic                   busy,
   output logic                   timeoutErr
);

   localparam int M1     = (BaseCycle > StageCycle) ? BaseCycle : StageCycle;
   localparam int MaxCyc = (M1 > AckTimeout) ? M1 : AckTimeout;
   localparam int CW     = $clog2(MaxCyc + 1);
   localparam int IW     = (NumChannels > 1) ? $clog2(NumChannels) : 1;

   localparam logic [CW-1:0] BaseLd  = CW'(BaseCycle);
   localparam logic [CW-1:0] StageLd = CW'(StageCycle);
   localparam logic [CW-1:0] AckLd   = CW'(AckTimeout);
   localparam logic [CW-1:0] One     = CW'(1);
   localparam logic [IW-1:0] LastIdx = IW'(NumChannels - 1);

   typedef enum logic [1:0] {HOLD, GAP, WAITACK, DONE} state_t;

   state_t                   state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [CW-1:0]            ack_cnt_q, ack_cnt_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic [IW-1:0]            idx_prev;
   logic [NumChannels-1:0]   rst_out_q, rst_out_d;
   logic                     busy_q, busy_d;
   logic                     timeout_err_q, timeout_err_d;
   logic [CW-1:0]            ch_cnt_q [NumChannels];
   logic [CW-1:0]            ch_cnt_d [NumChannels];
   logic                     ch_idle;

   assign idx_prev = idx_q - IW'(1);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      ack_cnt_d     = ack_cnt_q;
      idx_d         = idx_q;
      rst_out_d     = rst_out_q;
      timeout_err_d = timeout_err_q;
      ch_cnt_d      = ch_cnt_q;
      ch_idle       = 1'b1;

      case (state_q)
         HOLD: begin
            cnt_d = cnt_q - One;
            if (cnt_q == One) begin
               rst_out_d[0] = 1'b0;
               cnt_d        = StageLd;
               ack_cnt_d    = AckLd;
               idx_d        = IW'(1);
               if (NumChannels == 1)  state_d = DONE;
               else if (UseAck != 0)  state_d = WAITACK;
               else                   state_d = GAP;
            end
         end
         GAP: begin
            cnt_d = cnt_q - One;
            if (cnt_q == One) begin
               rst_out_d[idx_q] = 1'b0;
               if (idx_q == LastIdx) begin
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + IW'(1);
                  if (UseAck != 0) begin
                     state_d   = WAITACK;
                     ack_cnt_d = AckLd;
                  end else begin
                     cnt_d = StageLd;
                  end
               end
            end
         end
         WAITACK: begin
            ack_cnt_d = ack_cnt_q - One;
            // An ack arriving on the expiry edge wins over the timeout.
            if (ackIn[idx_prev]) begin
               state_d = GAP;
               cnt_d   = StageLd;
            end else if (ack_cnt_q == One) begin
               timeout_err_d = 1'b1;
               state_d       = GAP;
               cnt_d         = StageLd;
            end
         end
         default: begin
            for (int i = 0; i < NumChannels; i++) begin
               if (swRstReq[i]) begin
                  ch_cnt_d[i]  = BaseLd;
                  rst_out_d[i] = 1'b1;
               end else if (ch_cnt_q[i] != '0) begin
                  ch_cnt_d[i] = ch_cnt_q[i] - One;
                  if (ch_cnt_q[i] == One) rst_out_d[i] = 1'b0;
               end
            end
         end
      endcase

      for (int i = 0; i < NumChannels; i++) begin
         if (ch_cnt_d[i] != '0) ch_idle = 1'b0;
      end
      busy_d = !((state_d == DONE) && ch_idle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= HOLD;
         cnt_q         <= BaseLd;
         ack_cnt_q     <= '0;
         idx_q         <= '0;
         rst_out_q     <= '1;
         busy_q        <= 1'b1;
         timeout_err_q <= 1'b0;
         ch_cnt_q      <= '{default: '0};
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         ack_cnt_q     <= ack_cnt_d;
         idx_q         <= idx_d;
         rst_out_q     <= rst_out_d;
         busy_q        <= busy_d;
         timeout_err_q <= timeout_err_d;
         ch_cnt_q      <= ch_cnt_d;
      end
   end

   assign rstOut     = rst_out_q;
   assign busy       = busy_q;
   assign timeoutErr = timeout_err_q;

endmodule

// File: tb/tb_reset_sequencer_staged.sv
// Bench for reset_sequencer_staged: run-length vector table plus hand-written re-reset sequence, checked through a scoreboard queue.
module tb_reset_sequencer_staged;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0 = 1'b1, rst1 = 1'b1;
   logic [3:0] ack0 = '0, ack1 = '0, sw0 = '0, sw1 = '0;
   logic [3:0] ro0, ro1;
   logic       busy0, busy1, te0, te1;

   reset_sequencer_staged #(.UseAck(0)) u_dut0 (
      .clk(clk), .rst(rst0), .rstOut(ro0), .ackIn(ack0),
      .swRstReq(sw0), .busy(busy0), .timeoutErr(te0));

   reset_sequencer_staged #(.UseAck(1)) u_dut1 (
      .clk(clk), .rst(rst1), .rstOut(ro1), .ackIn(ack1),
      .swRstReq(sw1), .busy(busy1), .timeoutErr(te1));

   // n: edges this row lasts; expected values hold after every one of them
   typedef struct {
      int         n;
      bit         sel;
      bit         r;
      logic [3:0] a;
      logic [3:0] s;
      logic [3:0] er;
      logic       eb;
      logic       ee;
   } row_t;

   typedef struct {
      bit         sel;
      logic [3:0] er;
      logic       eb;
      logic       ee;
      int         tag;
   } exp_t;

   row_t tbl[$];
   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   function automatic void add(input int n, input bit sel, input bit r,
                               input logic [3:0] a, input logic [3:0] s,
                               input logic [3:0] er, input logic eb, input logic ee);
      row_t x;
      x.n = n; x.sel = sel; x.r = r; x.a = a; x.s = s;
      x.er = er; x.eb = eb; x.ee = ee;
      tbl.push_back(x);
   endfunction

   task automatic step(input bit sel, input bit r, input logic [3:0] a,
                       input logic [3:0] s, input logic [3:0] er,
                       input logic eb, input logic ee, input int tag);
      exp_t x;
      @(negedge clk);
      if (sel) begin rst1 = r; ack1 = a; sw1 = s; end
      else     begin rst0 = r; ack0 = a; sw0 = s; end
      x.sel = sel; x.er = er; x.eb = eb; x.ee = ee; x.tag = tag;
      sb.push_back(x);
   endtask

   task automatic cmp(input string what, input int tag,
                      input logic [3:0] got, input logic [3:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s row%0d got=%b want=%b", what, tag, got, want);
      end
   endtask

   exp_t       chk_x;
   logic [3:0] g_r;
   logic       g_b, g_e;

   always @(posedge clk) begin
      #1;
      if (sb.size() != 0) begin
         chk_x = sb.pop_front();
         g_r = chk_x.sel ? ro1   : ro0;
         g_b = chk_x.sel ? busy1 : busy0;
         g_e = chk_x.sel ? te1   : te0;
         cmp("rstOut",     chk_x.tag, g_r, chk_x.er);
         cmp("busy",       chk_x.tag, {3'b0, g_b}, {3'b0, chk_x.eb});
         cmp("timeoutErr", chk_x.tag, {3'b0, g_e}, {3'b0, chk_x.ee});
      end
   end

   initial begin
      // plain staged release, no acks
      add(3, 0, 1, 4'h0, 4'h0, 4'b1111, 1, 0);
      add(7, 0, 0, 4'h0, 4'h0, 4'b1111, 1, 0);
      add(4, 0, 0, 4'h0, 4'h0, 4'b1110, 1, 0);
      add(4, 0, 0, 4'h0, 4'h0, 4'b1100, 1, 0);
      add(4, 0, 0, 4'h0, 4'h0, 4'b1000, 1, 0);
      add(5, 0, 0, 4'h0, 4'h0, 4'b0000, 0, 0);
      // single software re-reset, then two channels at once
      add(1, 0, 0, 4'h0, 4'b0100, 4'b0100, 1, 0);
      add(7, 0, 0, 4'h0, 4'h0,    4'b0100, 1, 0);
      add(2, 0, 0, 4'h0, 4'h0,    4'b0000, 0, 0);
      add(1, 0, 0, 4'h0, 4'b1001, 4'b1001, 1, 0);
      add(7, 0, 0, 4'h0, 4'h0,    4'b1001, 1, 0);
      add(1, 0, 0, 4'h0, 4'h0,    4'b0000, 0, 0);
      // global reset re-pulsed mid-sequence
      add(3, 0, 1, 4'h0, 4'h0, 4'b1111, 1, 0);
      add(7, 0, 0, 4'h0, 4'h0, 4'b1111, 1, 0);
      add(4, 0, 0, 4'h0, 4'h0, 4'b1110, 1, 0);
      add(3, 0, 0, 4'h0, 4'h0, 4'b1100, 1, 0);
      add(1, 0, 1, 4'h0, 4'h0, 4'b1111, 1, 0);
      add(7, 0, 0, 4'h0, 4'h0, 4'b1111, 1, 0);
      add(1, 0, 0, 4'h0, 4'h0, 4'b1110, 1, 0);
      // software requests during the sequence are ignored
      add(3, 0, 1, 4'h0, 4'hF, 4'b1111, 1, 0);
      add(7, 0, 0, 4'h0, 4'hF, 4'b1111, 1, 0);
      add(4, 0, 0, 4'h0, 4'hF, 4'b1110, 1, 0);
      add(4, 0, 0, 4'h0, 4'hF, 4'b1100, 1, 0);
      add(4, 0, 0, 4'h0, 4'hF, 4'b1000, 1, 0);
      add(5, 0, 0, 4'h0, 4'h0, 4'b0000, 0, 0);
      // ack mode: ack[0] held from R0+1, later channels' acks high early
      add(3, 1, 1, 4'h0,    4'h0, 4'b1111, 1, 0);
      add(7, 1, 0, 4'b1110, 4'h0, 4'b1111, 1, 0);
      add(1, 1, 0, 4'b1110, 4'h0, 4'b1110, 1, 0);
      add(4, 1, 0, 4'b1111, 4'h0, 4'b1110, 1, 0);
      add(5, 1, 0, 4'b1111, 4'h0, 4'b1100, 1, 0);
      add(5, 1, 0, 4'b1111, 4'h0, 4'b1000, 1, 0);
      add(3, 1, 0, 4'b1111, 4'h0, 4'b0000, 0, 0);
      // ack mode: ack[0] pulse at R0+3, ack[1] from R1+1, ack[2] never
      add(3,  1, 1, 4'h0,    4'h0, 4'b1111, 1, 0);
      add(7,  1, 0, 4'h0,    4'h0, 4'b1111, 1, 0);
      add(3,  1, 0, 4'h0,    4'h0, 4'b1110, 1, 0);
      add(1,  1, 0, 4'b0001, 4'h0, 4'b1110, 1, 0);
      add(3,  1, 0, 4'h0,    4'h0, 4'b1110, 1, 0);
      add(1,  1, 0, 4'h0,    4'h0, 4'b1100, 1, 0);
      add(4,  1, 0, 4'b0010, 4'h0, 4'b1100, 1, 0);
      add(16, 1, 0, 4'h0,    4'h0, 4'b1000, 1, 0);
      add(4,  1, 0, 4'h0,    4'h0, 4'b1000, 1, 1);
      add(5,  1, 0, 4'h0,    4'h0, 4'b0000, 0, 1);
      add(2,  1, 1, 4'h0,    4'h0, 4'b1111, 1, 0);
      // ack mode: ack on the same edge the timeout expires
      add(7,  1, 0, 4'h0,    4'h0, 4'b1111, 1, 0);
      add(16, 1, 0, 4'h0,    4'h0, 4'b1110, 1, 0);
      add(1,  1, 0, 4'b0001, 4'h0, 4'b1110, 1, 0);
      add(3,  1, 0, 4'h0,    4'h0, 4'b1110, 1, 0);
      add(4,  1, 0, 4'h0,    4'h0, 4'b1100, 1, 0);

      for (int k = 0; k < tbl.size(); k++) begin
         for (int c = 0; c < tbl[k].n; c++) begin
            step(tbl[k].sel, tbl[k].r, tbl[k].a, tbl[k].s,
                 tbl[k].er, tbl[k].eb, tbl[k].ee, k);
         end
      end

      // software reset on channel 2 extended by a second request at T+5
      step(0, 0, 4'h0, 4'b0100, 4'b0100, 1, 0, 100);
      repeat (4) step(0, 0, 4'h0, 4'h0, 4'b0100, 1, 0, 101);
      step(0, 0, 4'h0, 4'b0100, 4'b0100, 1, 0, 102);
      repeat (7) step(0, 0, 4'h0, 4'h0, 4'b0100, 1, 0, 103);
      step(0, 0, 4'h0, 4'h0, 4'b0000, 0, 0, 104);
      step(0, 0, 4'h0, 4'h0, 4'b0000, 0, 0, 105);

      repeat (3) @(negedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
